// File: rtl/mux_rr_n1.sv
// N:1 registered multiplexer with per-channel valid/ready, fixed-select or
// round-robin arbitration, and a one-word output register with backpressure.
module mux_rr_n1 #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          selector,
    input  logic [CHANNELS-1:0]       valid_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [CHANNELS-1:0]       ready_in,
    output logic [WIDTH-1:0]          data_out,
    output logic                      valid_out,
    output logic [SEL_W-1:0]          sel_out,
    input  logic                      ready_out
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic             load_en;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;
    int               idx;

    assign load_en = !valid_q || ready_out;

    // Round-robin search starts just past the last granted channel and wraps.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!mode) begin
            if (int'(selector) < CHANNELS) begin
                grant_vld = 1'b1;
                grant_idx = selector;
            end
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                idx = (int'(last_grant_q) + k) % CHANNELS;
                if (!grant_vld && valid_in[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        ready_in   = '0;
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data  = data_in[i*WIDTH +: WIDTH];
                ready_in[i] = reset_L && load_en && grant_vld;
            end
        end
    end

    assign xfer = |(valid_in & ready_in);

    always_comb begin
        data_d       = data_q;
        sel_d        = sel_q;
        valid_d      = valid_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            data_d  = grant_data;
            sel_d   = grant_idx;
            valid_d = 1'b1;
            if (mode) begin
                last_grant_d = grant_idx;
            end
        end else if (ready_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            data_q       <= '0;
            sel_q        <= '0;
            valid_q      <= 1'b0;
            last_grant_q <= SEL_W'(CHANNELS - 1);
        end else begin
            data_q       <= data_d;
            sel_q        <= sel_d;
            valid_q      <= valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign data_out  = data_q;
    assign sel_out   = sel_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_mux_rr_n1.sv
// Directed-vector bench for mux_rr_n1: a 4-channel instance driven from a table
// and a 3-channel instance exercising the out-of-range selector.
module tb_mux_rr_n1;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic       rst4_n, mode4, rdy4;
    logic [1:0] sel4;
    logic [3:0] vin4, rin4;
    logic [7:0] din4;
    logic [1:0] dout4, sout4;
    logic       vout4;

    mux_rr_n1 #(.WIDTH(2), .CHANNELS(4), .SEL_W(2)) dut4 (
        .clk(clk), .reset_L(rst4_n), .mode(mode4), .selector(sel4),
        .valid_in(vin4), .data_in(din4), .ready_in(rin4),
        .data_out(dout4), .valid_out(vout4), .sel_out(sout4), .ready_out(rdy4)
    );

    // 3-channel instance
    logic       rst3_n, mode3, rdy3;
    logic [1:0] sel3;
    logic [2:0] vin3, rin3;
    logic [5:0] din3;
    logic [1:0] dout3, sout3;
    logic       vout3;

    mux_rr_n1 #(.WIDTH(2), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset_L(rst3_n), .mode(mode3), .selector(sel3),
        .valid_in(vin3), .data_in(din3), .ready_in(rin3),
        .data_out(dout3), .valid_out(vout3), .sel_out(sout3), .ready_out(rdy3)
    );

    typedef struct {
        logic       rst_n;
        logic       md;
        logic [1:0] sel;
        logic [3:0] vin;
        logic [7:0] din;
        logic       rdy;
        logic [3:0] exp_rin;
        logic       exp_vo;
        logic [1:0] exp_do;
        logic [1:0] exp_so;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ch i carries value i / reversed values
    localparam logic [7:0] D_INC = 8'b11_10_01_00;
    localparam logic [7:0] D_DEC = 8'b00_01_10_11;

    task automatic add(input logic r, input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic [7:0] d, input logic ro, input logic [3:0] er,
                       input logic evo, input logic [1:0] edo, input logic [1:0] eso);
        vec_t t;
        t.rst_n = r; t.md = m; t.sel = s; t.vin = v; t.din = d; t.rdy = ro;
        t.exp_rin = er; t.exp_vo = evo; t.exp_do = edo; t.exp_so = eso;
        vecs.push_back(t);
    endtask

    initial begin
        rst4_n = 1'b0; mode4 = 1'b0; sel4 = 2'd0; vin4 = '0; din4 = '0; rdy4 = 1'b0;
        rst3_n = 1'b0; mode3 = 1'b0; sel3 = 2'd0; vin3 = '0; din3 = '0; rdy3 = 1'b0;

        //   rst mode sel  vin      data   rdy  ready_in  vo  do  so
        // reset with all inputs active, then idle
        add(0, 0, 2, 4'b1111, D_INC, 1, 4'b0000, 0, 0, 0);
        add(0, 0, 2, 4'b1111, D_INC, 1, 4'b0000, 0, 0, 0);
        add(1, 0, 2, 4'b0000, D_INC, 1, 4'b0100, 0, 0, 0);
        add(1, 0, 2, 4'b0000, D_INC, 1, 4'b0100, 0, 0, 0);
        // fixed select ch2 with 3 stalled cycles
        add(1, 0, 2, 4'b1111, D_INC, 0, 4'b0100, 1, 2, 2);
        add(1, 0, 2, 4'b1111, D_DEC, 0, 4'b0000, 1, 2, 2);
        add(1, 0, 2, 4'b1111, D_DEC, 0, 4'b0000, 1, 2, 2);
        add(1, 0, 2, 4'b1111, D_DEC, 0, 4'b0000, 1, 2, 2);
        add(1, 0, 2, 4'b1111, D_DEC, 1, 4'b0100, 1, 1, 2);
        add(1, 0, 2, 4'b1111, D_INC, 1, 4'b0100, 1, 2, 2);
        // round-robin over all four, one word per cycle
        add(1, 1, 0, 4'b1111, D_INC, 1, 4'b0001, 1, 0, 0);
        add(1, 1, 0, 4'b1111, D_INC, 1, 4'b0010, 1, 1, 1);
        add(1, 1, 0, 4'b1111, D_INC, 1, 4'b0100, 1, 2, 2);
        add(1, 1, 0, 4'b1111, D_INC, 1, 4'b1000, 1, 3, 3);
        add(1, 1, 0, 4'b1111, D_INC, 1, 4'b0001, 1, 0, 0);
        add(1, 1, 0, 4'b1111, D_INC, 1, 4'b0010, 1, 1, 1);
        add(1, 1, 0, 4'b1111, D_INC, 1, 4'b0100, 1, 2, 2);
        add(1, 1, 0, 4'b1111, D_INC, 1, 4'b1000, 1, 3, 3);
        // skip and wrap with ch1/ch3 only, then ch0 after a ch3 grant
        add(1, 1, 0, 4'b1010, D_INC, 1, 4'b0010, 1, 1, 1);
        add(1, 1, 0, 4'b1010, D_INC, 1, 4'b1000, 1, 3, 3);
        add(1, 1, 0, 4'b1010, D_INC, 1, 4'b0010, 1, 1, 1);
        add(1, 1, 0, 4'b1010, D_INC, 1, 4'b1000, 1, 3, 3);
        add(1, 1, 0, 4'b0001, D_DEC, 1, 4'b0001, 1, 3, 0);
        // drain with nothing valid: data/sel hold
        add(1, 1, 0, 4'b0000, D_INC, 1, 4'b0000, 0, 3, 0);
        // mode 0 transfer must not move the round-robin pointer
        add(1, 0, 1, 4'b1111, D_INC, 1, 4'b0010, 1, 1, 1);
        add(1, 1, 0, 4'b1111, D_INC, 1, 4'b0010, 1, 1, 1);
        // stall, then reset mid-stream, then lowest valid wins
        add(1, 1, 0, 4'b1111, D_INC, 0, 4'b0000, 1, 1, 1);
        add(0, 1, 0, 4'b0010, D_INC, 1, 4'b0000, 0, 0, 0);
        add(1, 1, 0, 4'b0110, D_INC, 1, 4'b0010, 1, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst4_n = vecs[i].rst_n; mode4 = vecs[i].md; sel4 = vecs[i].sel;
            vin4 = vecs[i].vin; din4 = vecs[i].din; rdy4 = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d ready_in", i), 32'(rin4), 32'(vecs[i].exp_rin));
            @(posedge clk); #1;
            chk($sformatf("v%0d valid_out", i), 32'(vout4), 32'(vecs[i].exp_vo));
            chk($sformatf("v%0d data_out", i), 32'(dout4), 32'(vecs[i].exp_do));
            chk($sformatf("v%0d sel_out", i), 32'(sout4), 32'(vecs[i].exp_so));
        end

        // 3-channel: load a word, then select the nonexistent channel 3
        rst3_n = 1'b0; mode3 = 1'b0; sel3 = 2'd0; vin3 = 3'b111; din3 = 6'b11_10_01; rdy3 = 1'b1;
        @(posedge clk); #1;
        chk("c3 reset valid_out", 32'(vout3), 32'd0);
        rst3_n = 1'b1; rdy3 = 1'b0;
        #1;
        chk("c3 ready_in sel0", 32'(rin3), 32'b001);
        @(posedge clk); #1;
        chk("c3 load valid_out", 32'(vout3), 32'd1);
        chk("c3 load data_out", 32'(dout3), 32'd1);
        sel3 = 2'd3;
        #1;
        chk("c3 oor stall ready_in", 32'(rin3), 32'b000);
        @(posedge clk); #1;
        chk("c3 oor stall valid_out", 32'(vout3), 32'd1);
        rdy3 = 1'b1;
        #1;
        chk("c3 oor ready_in", 32'(rin3), 32'b000);
        @(posedge clk); #1;
        chk("c3 oor drain valid_out", 32'(vout3), 32'd0);
        chk("c3 oor drain data_out", 32'(dout3), 32'd1);
        chk("c3 oor drain sel_out", 32'(sout3), 32'd0);
        #1;
        chk("c3 oor idle ready_in", 32'(rin3), 32'b000);
        @(posedge clk); #1;
        chk("c3 oor idle valid_out", 32'(vout3), 32'd0);
        // round-robin on 3 channels: reset pointer is ch2, so ch0 first, then wrap
        mode3 = 1'b1;
        #1;
        chk("c3 rr ready_in a", 32'(rin3), 32'b001);
        @(posedge clk); #1;
        chk("c3 rr sel a", 32'(sout3), 32'd0);
        vin3 = 3'b101;
        #1;
        chk("c3 rr ready_in b", 32'(rin3), 32'b100);
        @(posedge clk); #1;
        chk("c3 rr sel b", 32'(sout3), 32'd2);
        chk("c3 rr data b", 32'(dout3), 32'd3);
        #1;
        chk("c3 rr ready_in wrap", 32'(rin3), 32'b001);
        @(posedge clk); #1;
        chk("c3 rr sel wrap", 32'(sout3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
